// File: rtl/vending_credit_ctrl.sv
// vending_credit_ctrl
//   Coin-credit controller for the vending machine. It accumulates inserted coins,
//   handles item selection and cancel, and pays change out one coin per cycle. It
//   feeds the two-digit seven-segment display stage, which latches value on every
//   clock edge where load is high.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   coin_lo      in   1-cycle pulse, small coin inserted
//   coin_hi      in   1-cycle pulse, large coin inserted
//   sel[2:0]     in   one-hot item select pulse {C,B,A}; other codes ignored
//   cancel       in   1-cycle pulse, refund all credit
//   value[7:0]   out  current credit, binary, zero-extended
//   load         out  high in the cycle value takes a new value (high in reset)
//   dispense     out  one-hot 1-cycle pulse, item released {C,B,A}
//   coin_out_lo  out  1-cycle pulse, return one small coin
//   coin_out_hi  out  1-cycle pulse, return one large coin
//   coin_reject  out  1-cycle pulse, inserted coin(s) bounced
//   busy         out  high in VEND and CHANGE
//   state_dbg    out  current FSM state (0 IDLE, 1 COLLECT, 2 VEND, 3 CHANGE)
//
// Every output is a register, so each response shows up one cycle after the
// input pulse. The state register names the state whose outputs are visible:
// a vend or a payout step is performed on the edge that enters the state.
module vending_credit_ctrl #(
  parameter int COIN_LO    = 5,
  parameter int COIN_HI    = 10,
  parameter int PRICE_A    = 15,
  parameter int PRICE_B    = 25,
  parameter int PRICE_C    = 40,
  parameter int MAX_CREDIT = 95
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_lo,
  input  logic       coin_hi,
  input  logic [2:0] sel,
  input  logic       cancel,
  output logic [7:0] value,
  output logic       load,
  output logic [2:0] dispense,
  output logic       coin_out_lo,
  output logic       coin_out_hi,
  output logic       coin_reject,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [7:0] C_LO  = 8'(COIN_LO);
  localparam logic [7:0] C_HI  = 8'(COIN_HI);
  localparam logic [7:0] P_A   = 8'(PRICE_A);
  localparam logic [7:0] P_B   = 8'(PRICE_B);
  localparam logic [7:0] P_C   = 8'(PRICE_C);
  localparam logic [7:0] C_MAX = 8'(MAX_CREDIT);

  state_t     state, state_n;
  logic [7:0] credit, credit_n;
  logic       load_n, out_lo_n, out_hi_n, reject_n, busy_n;
  logic [2:0] dispense_n;

  logic [7:0] add, sum, price, pay_amt;
  logic       coin_in, sel_ok, pay_hi;

  always_comb begin
    add     = (coin_lo ? C_LO : 8'd0) + (coin_hi ? C_HI : 8'd0);
    coin_in = coin_lo | coin_hi;
    // Worst case is MAX_CREDIT + both coins, well inside 8 bits.
    sum     = credit + add;
    sel_ok  = 1'b1;
    case (sel)
      3'b001:  price = P_A;
      3'b010:  price = P_B;
      3'b100:  price = P_C;
      default: begin
        price  = 8'd0;
        sel_ok = 1'b0;
      end
    endcase
    // Credit is always a multiple of COIN_LO, so a non-zero credit covers at
    // least one small coin and the payout step cannot underflow.
    pay_hi  = credit >= C_HI;
    pay_amt = pay_hi ? C_HI : C_LO;
  end

  always_comb begin
    state_n    = state;
    credit_n   = credit;
    load_n     = 1'b0;
    dispense_n = 3'b000;
    out_lo_n   = 1'b0;
    out_hi_n   = 1'b0;
    reject_n   = 1'b0;

    case (state)
      IDLE, COLLECT: begin
        if (state == COLLECT && cancel) begin
          // First refund coin goes out on the same edge as the cancel.
          state_n  = CHANGE;
          reject_n = coin_in;
          credit_n = credit - pay_amt;
          out_hi_n = pay_hi;
          out_lo_n = !pay_hi;
          load_n   = 1'b1;
        end else if (state == COLLECT && sel_ok && credit >= price) begin
          state_n    = VEND;
          reject_n   = coin_in;
          dispense_n = sel;
          credit_n   = credit - price;
          load_n     = 1'b1;
        end else if (coin_in) begin
          // Unaffordable select falls through here, so coins still count.
          if (sum <= C_MAX) begin
            credit_n = sum;
            load_n   = 1'b1;
            state_n  = COLLECT;
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      VEND, CHANGE: begin
        reject_n = coin_in;
        if (credit != 8'd0) begin
          state_n  = CHANGE;
          credit_n = credit - pay_amt;
          out_hi_n = pay_hi;
          out_lo_n = !pay_hi;
          load_n   = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == VEND) || (state_n == CHANGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      credit      <= 8'd0;
      load        <= 1'b1;
      dispense    <= 3'b000;
      coin_out_lo <= 1'b0;
      coin_out_hi <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      load        <= load_n;
      dispense    <= dispense_n;
      coin_out_lo <= out_lo_n;
      coin_out_hi <= out_hi_n;
      coin_reject <= reject_n;
      busy        <= busy_n;
    end
  end

  assign value     = credit;
  assign state_dbg = state;

endmodule
